// File: rtl/data_mem_responder.sv
// Word-access data memory responder: valid/ready request, fixed-latency response, byte-lane storage.
// Optional macro ALIGN_CHECK_EN: when defined, misaligned (addr[1:0]!=0) accesses return an error.
`default_nettype none

module data_mem_responder #(
  parameter int DEPTH_BYTES = 4096,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     mem_addr,
  input  logic            mem_write_en,
  input  logic [0:3][7:0] mem_data_in,
  output logic [0:3][7:0] mem_data_out,
  output logic            resp_valid,
  output logic            resp_err
);

  localparam int          AW        = $clog2(DEPTH_BYTES);
  localparam int          CW        = $clog2(LATENCY + 1);
  localparam logic [31:0] LAST_WORD = 32'(DEPTH_BYTES - 4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [31:0]     addr_q;
  logic            we_q;
  logic [0:3][7:0] data_q;

  logic [7:0] mem [0:DEPTH_BYTES-1];

  logic            accept;
  logic            enter_resp;
  logic [31:0]     c_addr;
  logic            c_we;
  logic [0:3][7:0] c_data;
  logic            c_err;
  logic            align_err;
  logic [AW-1:0]   c_base;

  assign accept = req_valid && req_ready;

  // With LATENCY=1 the commit edge is the acceptance edge, so the live request is used directly.
  always_comb begin
    enter_resp = 1'b0;
    c_addr     = addr_q;
    c_we       = we_q;
    c_data     = data_q;
    if (LATENCY == 1) begin
      enter_resp = accept;
      c_addr     = mem_addr;
      c_we       = mem_write_en;
      c_data     = mem_data_in;
    end else begin
      enter_resp = (state == WAIT) && (cnt == '0);
    end
  end

`ifdef ALIGN_CHECK_EN
  assign align_err = |c_addr[1:0];
`else
  assign align_err = 1'b0;
`endif

  assign c_err  = (c_addr > LAST_WORD) || align_err;
  assign c_base = c_addr[AW-1:0];

  // Storage is deliberately not reset; a reset edge must never commit a write.
  always_ff @(posedge clk) begin
    if (!rst_b && enter_resp && c_we && !c_err) begin
      for (int i = 0; i < 4; i++) begin
        mem[c_base + AW'(i)] <= c_data[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state        <= IDLE;
      cnt          <= '0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_err     <= 1'b0;
      mem_data_out <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      data_q       <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;

      if (enter_resp) begin
        resp_valid <= 1'b1;
        resp_err   <= c_err;
        if (!c_we && !c_err) begin
          for (int i = 0; i < 4; i++) begin
            mem_data_out[i] <= mem[c_base + AW'(i)];
          end
        end
      end

      case (state)
        IDLE, RESP: begin
          if (accept) begin
            addr_q <= mem_addr;
            we_q   <= mem_write_en;
            data_q <= mem_data_in;
            if (LATENCY == 1) begin
              state     <= RESP;
              req_ready <= 1'b1;
            end else begin
              state     <= WAIT;
              cnt       <= CW'(LATENCY - 2);
              req_ready <= 1'b0;
            end
          end else begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (DEPTH_BYTES=4096, LATENCY=2).
`default_nettype none

module tb_data_mem_responder;

  logic            clk;
  logic            rst_b;
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     mem_addr;
  logic            mem_write_en;
  logic [0:3][7:0] mem_data_in;
  logic [0:3][7:0] mem_data_out;
  logic            resp_valid;
  logic            resp_err;

  int tests;
  int failed;
  int n;

  data_mem_responder #(
    .DEPTH_BYTES(4096),
    .LATENCY    (2)
  ) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .mem_addr    (mem_addr),
    .mem_write_en(mem_write_en),
    .mem_data_in (mem_data_in),
    .mem_data_out(mem_data_out),
    .resp_valid  (resp_valid),
    .resp_err    (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] out_word();
    return {mem_data_out[3], mem_data_out[2], mem_data_out[1], mem_data_out[0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for one cycle; returns 1 ns after the acceptance edge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] w);
    req_valid    = 1'b1;
    mem_write_en = we;
    mem_addr     = addr;
    mem_data_in  = {w[7:0], w[15:8], w[23:16], w[31:24]};
    tick();
    req_valid    = 1'b0;
    mem_write_en = 1'b0;
    mem_addr     = 32'hFFFF_FFFF;
    mem_data_in  = '0;
  endtask

  // Counts edges after the acceptance edge until resp_valid is seen (bounded).
  task automatic wait_resp(input string tag, output int cycles);
    cycles = 0;
    while (!resp_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    if (!resp_valid) chk({tag, "_timeout"}, 32'(resp_valid), 32'd1);
  endtask

  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] w, input logic exp_err);
    issue(we, addr, w);
    wait_resp(tag, n);
    chk({tag, "_err"}, 32'(resp_err), 32'(exp_err));
    tick();
  endtask

  initial begin
    tests        = 0;
    failed       = 0;
    rst_b        = 1'b1;
    req_valid    = 1'b0;
    mem_write_en = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;

    // Reset state
    tick();
    tick();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    rst_b = 1'b0;
    tick();
    tick();
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_valid", 32'(resp_valid), 32'd0);
    chk("idle_err", 32'(resp_err), 32'd0);
    chk("idle_data", out_word(), 32'h0000_0000);

    // Write 0x10 then read it back; LATENCY=2 means resp_valid is seen one edge after acceptance
    issue(1'b1, 32'h10, 32'h1234_5678);
    chk("wr_ready_T1", 32'(req_ready), 32'd0);
    chk("wr_valid_T1", 32'(resp_valid), 32'd0);
    wait_resp("wr10", n);
    chk("wr10_lat", 32'(n), 32'd1);
    chk("wr10_err", 32'(resp_err), 32'd0);
    chk("wr10_data_hold", out_word(), 32'h0000_0000);
    tick();
    chk("wr10_pulse", 32'(resp_valid), 32'd0);
    access("rd10", 1'b0, 32'h10, 32'h0, 1'b0);
    chk("rd10_data", out_word(), 32'h1234_5678);

    // Back-to-back: read accepted in the write's RESP cycle
    issue(1'b1, 32'h20, 32'hDEAD_BEEF);
    wait_resp("wr20", n);
    chk("wr20_ready_in_resp", 32'(req_ready), 32'd1);
    issue(1'b0, 32'h20, 32'h0);
    chk("b2b_valid_gap", 32'(resp_valid), 32'd0);
    wait_resp("rd20", n);
    chk("rd20_lat", 32'(n), 32'd1);
    chk("rd20_err", 32'(resp_err), 32'd0);
    chk("rd20_data", out_word(), 32'hDEAD_BEEF);
    tick();

    // Range boundary
    access("wrffc", 1'b1, 32'hFFC, 32'hCAFE_F00D, 1'b0);
    access("rdffc", 1'b0, 32'hFFC, 32'h0, 1'b0);
    chk("rdffc_data", out_word(), 32'hCAFE_F00D);
    access("rdffd", 1'b0, 32'hFFD, 32'h0, 1'b1);
    chk("rdffd_data", out_word(), 32'hCAFE_F00D);
    access("rd10000", 1'b0, 32'h0001_0000, 32'h0, 1'b1);
    chk("rd10000_data", out_word(), 32'hCAFE_F00D);
    access("wrffd", 1'b1, 32'hFFD, 32'h5555_5555, 1'b1);
    access("rdffc2", 1'b0, 32'hFFC, 32'h0, 1'b0);
    chk("rdffc2_data", out_word(), 32'hCAFE_F00D);

    // Reset during WAIT aborts the write
    access("wr30a", 1'b1, 32'h30, 32'h1122_3344, 1'b0);
    issue(1'b1, 32'h30, 32'hAABB_CCDD);
    chk("abort_in_wait", 32'(req_ready), 32'd0);
    rst_b = 1'b1;
    #1;
    chk("async_ready", 32'(req_ready), 32'd1);
    chk("async_data", out_word(), 32'h0000_0000);
    #1;
    rst_b = 1'b0;
    tick();
    chk("abort_novalid1", 32'(resp_valid), 32'd0);
    tick();
    chk("abort_novalid2", 32'(resp_valid), 32'd0);
    access("rd30", 1'b0, 32'h30, 32'h0, 1'b0);
    chk("rd30_data", out_word(), 32'h1122_3344);

    // Misaligned write at 0x41
    access("wr40", 1'b1, 32'h40, 32'h0403_0201, 1'b0);
    access("wr44", 1'b1, 32'h44, 32'h0807_0605, 1'b0);
`ifdef ALIGN_CHECK_EN
    access("wr41", 1'b1, 32'h41, 32'hA5B6_C7D8, 1'b1);
    access("rd40", 1'b0, 32'h40, 32'h0, 1'b0);
    chk("rd40_data", out_word(), 32'h0403_0201);
    access("rd44", 1'b0, 32'h44, 32'h0, 1'b0);
    chk("rd44_data", out_word(), 32'h0807_0605);
    access("rd41", 1'b0, 32'h41, 32'h0, 1'b1);
    chk("rd41_data", out_word(), 32'h0807_0605);
`else
    access("wr41", 1'b1, 32'h41, 32'hA5B6_C7D8, 1'b0);
    access("rd41", 1'b0, 32'h41, 32'h0, 1'b0);
    chk("rd41_data", out_word(), 32'hA5B6_C7D8);
    access("rd40", 1'b0, 32'h40, 32'h0, 1'b0);
    chk("rd40_data", out_word(), 32'hB6C7_D801);
    access("rd44", 1'b0, 32'h44, 32'h0, 1'b0);
    chk("rd44_data", out_word(), 32'h0807_06A5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
